// File: rtl/rv32_muldiv_pkg.sv
// Shared encodings for the RV32 M-extension multiply/divide unit:
// funct3 operation codes, FSM state type and operand-signedness helpers.
package rv32_muldiv_pkg;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  function automatic logic is_div(input logic [2:0] op);
    return op[2];
  endfunction

  // rs1 is signed for MUL, MULH, MULHSU, DIV and REM.
  function automatic logic signed_a(input logic [2:0] op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
           (op == OP_DIV) || (op == OP_REM);
  endfunction

  // rs2 is signed for MUL, MULH, DIV and REM.
  function automatic logic signed_b(input logic [2:0] op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/rv32_muldiv_signfix.sv
// Conditional two's-complement negate: takes operand magnitudes at accept
// and restores the result sign after the unsigned iteration.
module rv32_muldiv_signfix #(
  parameter int W = 64
) (
  input  logic [W-1:0] a,
  input  logic         neg,
  output logic [W-1:0] y
);

  assign y = neg ? (~a + {{(W-1){1'b0}}, 1'b1}) : a;

endmodule

// File: rtl/rv32_muldiv_unit.sv
// Iterative RV32 M-extension unit: 1-bit/cycle shift-add multiplier and
// restoring divider on operand magnitudes, with a one-cycle sign fix-up.
module rv32_muldiv_unit #(
  parameter int XLEN           = 32,
  parameter bit ZERO_EARLY_OUT = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_op,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic            busy
);
  import rv32_muldiv_pkg::*;

  localparam int              CW      = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t            state;
  logic [2:0]        op_q;
  logic              neg_q;     // sign of product / quotient
  logic              neg_r;     // sign of remainder (follows dividend)
  logic [XLEN-1:0]   opnd_q;    // multiplicand magnitude, or divisor magnitude
  logic [2*XLEN-1:0] acc;       // product accumulator; low half doubles as dividend/quotient
  logic [XLEN-1:0]   rem;
  logic [CW-1:0]     cnt;

  // ---------------- accept-time decode ----------------
  logic            neg_a, neg_b;
  logic [XLEN-1:0] abs_a, abs_b;
  logic            special;
  logic [XLEN-1:0] special_res;

  assign neg_a = signed_a(in_op) & in_a[XLEN-1];
  assign neg_b = signed_b(in_op) & in_b[XLEN-1];

  rv32_muldiv_signfix #(.W(XLEN)) u_abs_a (.a(in_a), .neg(neg_a), .y(abs_a));
  rv32_muldiv_signfix #(.W(XLEN)) u_abs_b (.a(in_b), .neg(neg_b), .y(abs_b));

  // NOTE: every always_comb target gets a default first so no latch is inferred.
  always_comb begin
    special     = 1'b0;
    special_res = '0;
    if (is_div(in_op)) begin
      if (in_b == '0) begin
        special     = 1'b1;
        special_res = in_op[1] ? in_a : '1;
      end else if (!in_op[0] && in_a == MIN_NEG && in_b == '1) begin
        special     = 1'b1;
        special_res = in_op[1] ? '0 : in_a;
      end
    end else if (ZERO_EARLY_OUT && (in_a == '0 || in_b == '0)) begin
      special = 1'b1;
    end
  end

  // ---------------- iteration datapath ----------------
  logic [XLEN:0] mul_sum;
  logic [XLEN:0] rem_shift;   // XLEN+1-bit working remainder
  logic [XLEN:0] rem_diff;
  logic          rem_ge;

  assign mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd_q} : '0);
  assign rem_shift = {rem, acc[XLEN-1]};
  assign rem_diff  = rem_shift - {1'b0, opnd_q};
  assign rem_ge    = ~rem_diff[XLEN];

  // ---------------- sign fix-up ----------------
  logic [2*XLEN-1:0] fix_in, fix_out;
  logic              fix_neg;
  logic [XLEN-1:0]   fix_res;

  always_comb begin
    fix_in  = acc;
    fix_neg = neg_q;
    if (is_div(op_q)) begin
      fix_in = {{XLEN{1'b0}}, op_q[1] ? rem : acc[XLEN-1:0]};
      if (op_q[1]) fix_neg = neg_r;
    end
  end

  rv32_muldiv_signfix #(.W(2*XLEN)) u_fix (.a(fix_in), .neg(fix_neg), .y(fix_out));

  assign fix_res = (is_div(op_q) || op_q == OP_MUL) ? fix_out[XLEN-1:0]
                                                     : fix_out[2*XLEN-1:XLEN];

  // ---------------- control FSM ----------------
  // NOTE: the datapath registers are reset too, so a restarted unit never
  // exposes a stale product or remainder.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      op_q       <= OP_MUL;
      neg_q      <= 1'b0;
      neg_r      <= 1'b0;
      opnd_q     <= '0;
      acc        <= '0;
      rem        <= '0;
      cnt        <= '0;
      out_valid  <= 1'b0;
      out_result <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (in_valid && !flush) begin
            op_q  <= in_op;
            neg_q <= neg_a ^ neg_b;
            neg_r <= neg_a;
            cnt   <= CW'(XLEN - 1);
            rem   <= '0;
            if (is_div(in_op)) begin
              opnd_q <= abs_b;
              acc    <= {{XLEN{1'b0}}, abs_a};
            end else begin
              opnd_q <= abs_a;
              acc    <= {{XLEN{1'b0}}, abs_b};
            end
            if (special) begin
              out_result <= special_res;
              out_valid  <= 1'b1;
              state      <= ST_DONE;
            end else begin
              state <= ST_CALC;
            end
          end
        end

        ST_CALC: begin
          if (flush) begin
            state <= ST_IDLE;
          end else begin
            if (is_div(op_q)) begin
              rem            <= rem_ge ? rem_diff[XLEN-1:0] : rem_shift[XLEN-1:0];
              acc[XLEN-1:0]  <= {acc[XLEN-2:0], rem_ge};
            end else begin
              acc <= {mul_sum, acc[XLEN-1:1]};
            end
            cnt <= cnt - 1'b1;
            if (cnt == '0) state <= ST_FIX;
          end
        end

        ST_FIX: begin
          if (flush) begin
            state <= ST_IDLE;
          end else begin
            out_result <= fix_res;
            out_valid  <= 1'b1;
            state      <= ST_DONE;
          end
        end

        ST_DONE: begin
          if (flush || out_ready) begin
            out_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready = (state == ST_IDLE);
  assign busy     = (state != ST_IDLE);

endmodule

// File: tb/tb_rv32_muldiv_unit.sv
// Directed-vector bench for rv32_muldiv_unit (XLEN=32, ZERO_EARLY_OUT=1):
// results, latencies, special cases, backpressure, flush and reset.
module tb_rv32_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [31:0] in_a, in_b;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  rv32_muldiv_unit #(.XLEN(32), .ZERO_EARLY_OUT(1'b1)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called #1 after a rising edge with the unit idle; returns #1 after the accept edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_a     = $urandom;
    in_b     = $urandom;
    in_op    = 3'($urandom);
  endtask

  // Cycles from accept until out_valid is seen (bounded).
  task automatic wait_result(output int lat);
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run(input string tag, input logic [2:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int lat;
    issue(op, a, b);
    wait_result(lat);
    check({tag, " latency"}, 64'(lat), 64'(exp_lat));
    check(tag, out_result, exp);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, " back to idle"}, {out_valid, in_ready}, 2'b01);
  endtask

  initial begin
    int  lat;
    bit  seen;

    rst = 1'b1; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0;
    flush = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
    check("reset outputs", {out_valid, busy, in_ready, out_result}, {3'b001, 32'h0});
    @(posedge clk); #1;
    rst = 1'b0;

    // Multiplies
    run("MUL 7*-3",          3'd0, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 34);
    run("MULH min*min",      3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34);
    run("MULHU max*max",     3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34);
    run("MULHSU -1*max",     3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34);
    run("MUL zero early",    3'd0, 32'd0,        32'd5,         32'd0,         1);

    // Divides
    run("DIV -7/2",          3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 34);
    run("REM -7%2",          3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 34);
    run("DIVU 100/7",        3'd5, 32'd100,      32'd7,         32'd14,        34);
    run("REMU 100%7",        3'd7, 32'd100,      32'd7,         32'd2,         34);

    // Special cases
    run("DIV by zero",       3'd4, 32'd9,        32'd0,         32'hFFFF_FFFF, 1);
    run("REMU by zero",      3'd7, 32'd5,        32'd0,         32'd5,         1);
    run("DIV overflow",      3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run("REM overflow",      3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1);

    // Backpressure in DONE
    issue(3'd5, 32'd100, 32'd7);
    wait_result(lat);
    check("bp latency", 64'(lat), 64'd34);
    for (int i = 0; i < 10; i++) begin
      check("bp hold", {out_valid, in_ready, busy, out_result}, {3'b101, 32'd14});
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp release", {out_valid, in_ready, busy}, 3'b010);

    // Flush in IDLE beats in_valid
    in_valid = 1'b1; in_op = 3'd5; in_a = 32'd10; in_b = 32'd3; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    check("idle flush no accept", {busy, in_ready}, 2'b01);

    // Flush at CALC cycle 5
    issue(3'd4, 32'd1000, 32'd7);
    repeat (4) @(posedge clk);
    #1;
    check("calc busy", busy, 1'b1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("calc flush", {out_valid, busy, in_ready}, 3'b001);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) seen = 1'b1;
      @(posedge clk); #1;
    end
    check("flushed result discarded", seen, 1'b0);

    // Reset mid-CALC (out_result still holds 14 from the backpressure op)
    issue(3'd0, 32'd3, 32'd5);
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid-calc reset", {out_valid, busy, in_ready, out_result}, {3'b001, 32'h0});

    run("DIVU 10/3 after reset", 3'd5, 32'd10, 32'd3, 32'd3, 34);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
